// File: rtl/bert_quant_pkg.sv
// Shared defaults, scale fraction width and the FILL/HOLD state encoding for the
// requantize-and-pack path feeding the GELU stage.
package bert_quant_pkg;
   localparam int ACC_W_DEF    = 32;
   localparam int LANES_IN_DEF = 8;
   localparam int BEATS_DEF    = 4;
   localparam int SCALE_FRAC   = 16;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } rq_state_t;
endpackage

// File: rtl/requant_lane.sv
// One lane: q = sat8((acc * scale) >>> 16), scale is unsigned 16.16.
// REQUANT_ROUND_EN adds half an LSB before the shift (round half toward +inf).
module requant_lane
   import bert_quant_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [ACC_W-1:0] acc_i,
   input  logic [31:0]      scale_i,
   output logic [7:0]       q_o
);
   logic signed [63:0] acc_ext;
   logic signed [63:0] scale_ext;
   logic signed [63:0] prod;
   logic signed [63:0] shifted;

   assign acc_ext   = {{(64-ACC_W){acc_i[ACC_W-1]}}, acc_i};
   assign scale_ext = {32'd0, scale_i};

`ifdef REQUANT_ROUND_EN
   assign prod = (acc_ext * scale_ext) + (64'sd1 <<< (SCALE_FRAC - 1));
`else
   assign prod = acc_ext * scale_ext;
`endif

   assign shifted = prod >>> SCALE_FRAC;

   always_comb begin
      if (shifted > 64'sd127)
         q_o = 8'h7F;
      else if (shifted < -64'sd128)
         q_o = 8'h80;
      else
         q_o = shifted[7:0];
   end
endmodule

// File: rtl/requant_pack.sv
// Collects BEATS beats of LANES_IN accumulators, requantizes each lane to int8
// and presents the packed vector until accepted. Rounding via REQUANT_ROUND_EN.
//
// state | meaning
// FILL  | accepting beats, cnt = next beat slot
// HOLD  | packed vector valid, waiting for downstream accept
module requant_pack
   import bert_quant_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int LANES_IN = LANES_IN_DEF,
   parameter int BEATS    = BEATS_DEF
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        data_in_valid,
   output logic                        data_in_ready,
   input  logic [LANES_IN*ACC_W-1:0]   in_data,
   input  logic                        in_last,
   input  logic [31:0]                 in_scale,
   output logic                        data_out_valid,
   input  logic                        data_out_ready,
   output logic [8*LANES_IN*BEATS-1:0] out_data
);
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BEAT_W = 8 * LANES_IN;

   rq_state_t                   state_q, state_d;
   logic [CNT_W-1:0]            cnt_q, cnt_d;
   logic [31:0]                 scale_q, scale_d;
   logic [8*LANES_IN*BEATS-1:0] out_q, out_d;

   logic              in_fire, out_fire, closing;
   logic [CNT_W-1:0]  beat_idx;
   logic [31:0]       scale_eff;
   logic [BEAT_W-1:0] q_flat;

   // A beat accepted from HOLD always starts a new vector, so it lands in slot 0.
   assign beat_idx  = (state_q == ST_HOLD) ? '0 : cnt_q;
   assign scale_eff = (beat_idx == '0) ? in_scale : scale_q;
   assign in_fire   = data_in_valid && data_in_ready;
   assign out_fire  = data_out_valid && data_out_ready;
   assign closing   = in_last || (beat_idx == CNT_W'(BEATS - 1));

   for (genvar i = 0; i < LANES_IN; i++) begin : g_lane
      requant_lane #(.ACC_W(ACC_W)) u_lane (
         .acc_i   (in_data[ACC_W*i +: ACC_W]),
         .scale_i (scale_eff),
         .q_o     (q_flat[8*i +: 8])
      );
   end

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      scale_d        = scale_q;
      out_d          = out_q;
      data_in_ready  = 1'b1;
      data_out_valid = 1'b0;

      if (state_q == ST_HOLD) begin
         data_out_valid = 1'b1;
         data_in_ready  = data_out_ready;
         if (out_fire) begin
            state_d = ST_FILL;
            cnt_d   = '0;
         end
      end

      if (in_fire) begin
         if (beat_idx == '0)
            scale_d = in_scale;
         for (int b = 0; b < BEATS; b++) begin
            if (CNT_W'(b) == beat_idx)
               out_d[BEAT_W*b +: BEAT_W] = q_flat;
            else if (in_last && (CNT_W'(b) > beat_idx))
               out_d[BEAT_W*b +: BEAT_W] = '0;
         end
         if (closing) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
         end else begin
            state_d = ST_FILL;
            cnt_d   = beat_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FILL;
         cnt_q   <= '0;
         scale_q <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         scale_q <= scale_d;
         out_q   <= out_d;
      end
   end

   assign out_data = out_q;
endmodule
